// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned MD_XLEN   = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction and final result negation, shared by the mul and div paths.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_XLEN
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  md_op_t             op_i,
    output logic [WIDTH-1:0]   mag_a_o,
    output logic [WIDTH-1:0]   mag_b_o,
    output logic               neg_res_o,
    output logic               neg_rem_o,
    input  logic [2*WIDTH-1:0] raw_i,
    input  logic               neg_i,
    output logic [2*WIDTH-1:0] fixed_o
);

    logic a_signed;
    logic b_signed;
    logic a_neg;
    logic b_neg;

    always_comb begin
        // MUL keeps its low half regardless of signedness, so it is treated as unsigned
        a_signed  = op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed  = op_i inside {OP_MULH, OP_DIV, OP_REM};
        a_neg     = a_signed & a_i[WIDTH-1];
        b_neg     = b_signed & b_i[WIDTH-1];
        mag_a_o   = a_neg ? ('0 - a_i) : a_i;
        mag_b_o   = b_neg ? ('0 - b_i) : b_i;
        neg_res_o = a_neg ^ b_neg;
        neg_rem_o = a_neg;
        fixed_o   = neg_i ? ('0 - raw_i) : raw_i;
    end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module execute_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_XLEN,
    parameter int unsigned ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MDStartE,
    input  logic [2:0]       MDctrlE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             MDBusyE,
    output logic             MDDoneE,
    output logic [WIDTH-1:0] MDResultE
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    md_state_t        state_q, state_d;
    md_op_t           op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [DW-1:0]    prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic             in_neg_res, in_neg_rem;
    logic [DW-1:0]    fix_raw, fixed;
    logic             fix_neg;

    logic [WIDTH:0]   mul_sum, rem_shift, rem_diff;
    logic [DW-1:0]    mul_next;
    logic [WIDTH-1:0] rem_next, quot_next;
    logic             rem_ge, last_iter;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a_i       (SrcAE),
        .b_i       (SrcBE),
        .op_i      (md_op_t'(MDctrlE)),
        .mag_a_o   (mag_a),
        .mag_b_o   (mag_b),
        .neg_res_o (in_neg_res),
        .neg_rem_o (in_neg_rem),
        .raw_i     (fix_raw),
        .neg_i     (fix_neg),
        .fixed_o   (fixed)
    );

    // Shift-add multiply: multiplier sits in the low half of prod_q and shifts out as the
    // product shifts in. Restoring divide: dividend in opa_q shifts out, quotient shifts in.
    always_comb begin
        mul_sum   = {1'b0, prod_q[DW-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
        rem_shift = {rem_q, opa_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opb_q};
        rem_ge    = ~rem_diff[WIDTH];
        rem_next  = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quot_next = {opa_q[WIDTH-2:0], rem_ge};
        last_iter = (cnt_q == CW'(ITERS - 1));
    end

    always_comb begin
        fix_raw = '0;
        fix_neg = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef MULDIV_FAST_MUL_EN
                fix_raw = DW'(mag_a) * DW'(mag_b);
                fix_neg = in_neg_res;
`endif
            end
            ST_MUL: begin
                fix_raw = mul_next;
                fix_neg = neg_res_q;
            end
            ST_DIV: begin
                if (op_q inside {OP_REM, OP_REMU}) begin
                    fix_raw = DW'(rem_next);
                    fix_neg = neg_rem_q;
                end else begin
                    fix_raw = DW'(quot_next);
                    fix_neg = neg_res_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        rem_d     = rem_q;
        result_d  = result_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        MDBusyE   = 1'b0;
        MDDoneE   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (MDStartE) begin
                    MDBusyE   = 1'b1;
                    op_d      = md_op_t'(MDctrlE);
                    opa_d     = mag_a;
                    opb_d     = mag_b;
                    neg_res_d = in_neg_res;
                    neg_rem_d = in_neg_rem;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (!MDctrlE[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                        result_d = (MDctrlE[1:0] == 2'b00) ? fixed[WIDTH-1:0] : fixed[DW-1:WIDTH];
                        state_d  = ST_DONE;
`else
                        prod_d  = DW'(mag_a);
                        state_d = ST_MUL;
`endif
                    end else if (SrcBE == '0) begin
                        result_d = MDctrlE[1] ? SrcAE : DIV0_QUOT;
                        state_d  = ST_DONE;
                    end else if (!MDctrlE[0] && SrcAE == INT_MIN && SrcBE == '1) begin
                        result_d = MDctrlE[1] ? '0 : INT_MIN;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                MDBusyE = 1'b1;
                prod_d  = mul_next;
                cnt_d   = cnt_q + 1'b1;
                if (last_iter) begin
                    result_d = (op_q == OP_MUL) ? fixed[WIDTH-1:0] : fixed[DW-1:WIDTH];
                    state_d  = ST_DONE;
                end
            end
            ST_DIV: begin
                MDBusyE = 1'b1;
                rem_d   = rem_next;
                opa_d   = quot_next;
                cnt_d   = cnt_q + 1'b1;
                if (last_iter) begin
                    result_d = fixed[WIDTH-1:0];
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                MDDoneE = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (FlushE) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            MDBusyE  = 1'b0;
            MDDoneE  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            opa_q     <= '0;
            opb_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign MDResultE = result_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit against a 64-bit arithmetic reference model.
module tb_execute_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MDStartE;
    logic [2:0]  MDctrlE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        MDBusyE;
    logic        MDDoneE;
    logic [31:0] MDResultE;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    execute_muldiv_unit #(.WIDTH(32), .ITERS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .MDStartE  (MDStartE),
        .MDctrlE   (MDctrlE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .FlushE    (FlushE),
        .MDBusyE   (MDBusyE),
        .MDDoneE   (MDDoneE),
        .MDResultE (MDResultE)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        logic [63:0] pv;
        logic        ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; pv = p; return pv[31:0]; end
            3'd1: begin p = sa * sb; pv = p; return pv[63:32]; end
            3'd2: begin p = sa * ub; pv = p; return pv[63:32]; end
            3'd3: begin pv = {32'b0, a} * {32'b0, b}; return pv[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; pv = p; return pv[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; pv = p; return pv[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; pv = p; return pv[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; pv = p; return pv[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!op[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op in the cycle after the next rising edge and follows it to its done pulse.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_err);
        @(posedge clk); #1;
        MDStartE = 1'b1;
        MDctrlE  = op;
        SrcAE    = a;
        SrcBE    = b;
        FlushE   = 1'b0;
        lat      = -1;
        busy_err = 0;
        res      = 32'h0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (MDDoneE) begin
                if (MDBusyE) busy_err++;
                lat = c;
                res = MDResultE;
                break;
            end
            if (!MDBusyE) busy_err++;
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        MDStartE = 1'b0;
        FlushE   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; MDStartE = 1'b0; FlushE = 1'b0; MDctrlE = 3'd0; SrcAE = '0; SrcBE = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (MDBusyE !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", MDBusyE); end
        total++; if (MDDoneE !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", MDDoneE); end
        total++; if (MDResultE !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", MDResultE); end
    endtask

    task automatic test_mul_basic();
        logic [31:0] res, exp;
        int lat, berr;
        exp = ref_result(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, berr);
        total++; if (res !== exp) begin bad++; $display("FAIL mul_result: got %h want %h", res, exp); end
        total++; if (lat != ref_latency(3'd0, 32'd7, 32'hFFFF_FFFD)) begin
            bad++; $display("FAIL mul_latency: got %0d want %0d", lat, ref_latency(3'd0, 32'd7, 32'hFFFF_FFFD)); end
        total++; if (berr != 0) begin bad++; $display("FAIL mul_busy_window: bad cycles %0d want 0", berr); end
        go_idle();
        @(negedge clk);
        total++; if (MDDoneE !== 1'b0 || MDBusyE !== 1'b0) begin
            bad++; $display("FAIL mul_after_done: done=%b busy=%b want 0 0", MDDoneE, MDBusyE); end
        total++; if (MDResultE !== exp) begin bad++; $display("FAIL mul_hold: got %h want %h", MDResultE, exp); end
    endtask

    task automatic test_mul_high();
        logic [2:0]  ops [3];
        logic [31:0] as  [3];
        logic [31:0] res, exp;
        int lat, berr;
        ops = '{3'd3, 3'd1, 3'd2};
        as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            exp = ref_result(ops[i], as[i], 32'hFFFF_FFFF);
            run_op(ops[i], as[i], 32'hFFFF_FFFF, res, lat, berr);
            total++; if (res !== exp) begin bad++; $display("FAIL mulh_result op=%0d: got %h want %h", ops[i], res, exp); end
            total++; if (lat != ref_latency(ops[i], as[i], 32'hFFFF_FFFF) || berr != 0) begin
                bad++; $display("FAIL mulh_timing op=%0d: lat %0d busy_err %0d", ops[i], lat, berr); end
        end
        go_idle();
    endtask

    task automatic test_div();
        logic [2:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] res, exp;
        int lat, berr;
        ops = '{3'd4, 3'd6, 3'd5, 3'd7};
        as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        bs  = '{32'd2, 32'd2, 32'd7, 32'd7};
        for (int i = 0; i < 4; i++) begin
            exp = ref_result(ops[i], as[i], bs[i]);
            run_op(ops[i], as[i], bs[i], res, lat, berr);
            total++; if (res !== exp) begin bad++; $display("FAIL div_result op=%0d: got %h want %h", ops[i], res, exp); end
            total++; if (lat != 33 || berr != 0) begin
                bad++; $display("FAIL div_timing op=%0d: lat %0d busy_err %0d want 33 0", ops[i], lat, berr); end
        end
        go_idle();
    endtask

    task automatic test_special();
        logic [2:0]  ops [7];
        logic [31:0] as  [7];
        logic [31:0] bs  [7];
        logic [31:0] res, exp;
        int lat, berr;
        ops = '{3'd5, 3'd4, 3'd6, 3'd7, 3'd6, 3'd4, 3'd5};
        as  = '{32'd100, 32'd5, 32'd1234, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        bs  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            exp = ref_result(ops[i], as[i], bs[i]);
            run_op(ops[i], as[i], bs[i], res, lat, berr);
            total++; if (res !== exp) begin bad++; $display("FAIL special_result idx=%0d: got %h want %h", i, res, exp); end
            total++; if (lat != ref_latency(ops[i], as[i], bs[i]) || berr != 0) begin
                bad++; $display("FAIL special_timing idx=%0d: lat %0d want %0d busy_err %0d", i, lat,
                                ref_latency(ops[i], as[i], bs[i]), berr); end
        end
        go_idle();
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, berr, seen;
        seen = 0;
        @(posedge clk); #1;
        MDStartE = 1'b1; MDctrlE = 3'd4; SrcAE = 32'd1000; SrcBE = 32'd7;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (MDDoneE) seen++;
        end
        @(posedge clk); #1;
        FlushE = 1'b1; MDStartE = 1'b0;
        @(negedge clk);
        total++; if (MDBusyE !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", MDBusyE); end
        total++; if (MDDoneE !== 1'b0 || seen != 0) begin
            bad++; $display("FAIL flush_done: done=%b early=%0d want 0 0", MDDoneE, seen); end
        run_op(3'd5, 32'd10, 32'd3, res, lat, berr);
        total++; if (res !== ref_result(3'd5, 32'd10, 32'd3)) begin
            bad++; $display("FAIL flush_restart_result: got %h want %h", res, ref_result(3'd5, 32'd10, 32'd3)); end
        total++; if (lat != 33 || berr != 0) begin
            bad++; $display("FAIL flush_restart_timing: lat %0d busy_err %0d want 33 0", lat, berr); end
        go_idle();
        @(posedge clk); #1;
        MDStartE = 1'b1; MDctrlE = 3'd5; SrcAE = 32'd9; SrcBE = 32'd2; FlushE = 1'b1;
        @(negedge clk);
        total++; if (MDBusyE !== 1'b0) begin bad++; $display("FAIL flush_start_busy: got %b want 0", MDBusyE); end
        @(posedge clk); #1;
        MDStartE = 1'b0; FlushE = 1'b0;
        @(negedge clk);
        total++; if (MDBusyE !== 1'b0 || MDDoneE !== 1'b0) begin
            bad++; $display("FAIL flush_start_ignored: busy=%b done=%b want 0 0", MDBusyE, MDDoneE); end
        @(posedge clk); #1;
        MDStartE = 1'b1; MDctrlE = 3'd5; SrcAE = 32'd9; SrcBE = 32'd0;
        @(negedge clk);
        @(posedge clk); #1;
        MDStartE = 1'b0; FlushE = 1'b1;
        @(negedge clk);
        total++; if (MDDoneE !== 1'b0) begin bad++; $display("FAIL flush_in_done: got %b want 0", MDDoneE); end
        go_idle();
    endtask

    task automatic test_rst_mid();
        int dones;
        dones = 0;
        @(posedge clk); #1;
        MDStartE = 1'b1; MDctrlE = 3'd0; SrcAE = 32'd5; SrcBE = 32'd9; FlushE = 1'b0;
        for (int c = 0; c < 5; c++) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; MDStartE = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (MDBusyE !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", MDBusyE); end
        total++; if (MDDoneE !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", MDDoneE); end
        total++; if (MDResultE !== 32'h0) begin bad++; $display("FAIL rstmid_result: got %h want 0", MDResultE); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (MDDoneE || MDBusyE) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL rstmid_idle: active cycles %0d want 0", dones); end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res, exp;
        int lat, berr;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            exp = ref_result(op, a, b);
            run_op(op, a, b, res, lat, berr);
            total++; if (res !== exp) begin
                bad++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h want %h", op, a, b, res, exp); end
            total++; if (lat != ref_latency(op, a, b) || berr != 0) begin
                bad++; $display("FAIL rand_timing op=%0d a=%h b=%h: lat %0d want %0d busy_err %0d",
                                op, a, b, lat, ref_latency(op, a, b), berr); end
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_high();
        test_div();
        test_special();
        test_flush();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the Execute stage. It consumes the forwarded operands and the M-op control produced by the DEC-to-EXE pipeline register, and returns a 32-bit result. While an operation is in flight it drives a busy signal into the hazard logic. That logic stalls Fetch, Decode and the DEC-to-EXE register, so the operands and control stay stable until the result is ready.

Parameters:
WIDTH, 32, datapath width (operands, result)
ITERS, 32, iteration cycles for the multi-cycle mul/div paths; must equal WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
MDStartE  input  1  an M-extension op is valid in EXE
MDctrlE  input  3  funct3 op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcAE  input  WIDTH  forwarded rs1 value
SrcBE  input  WIDTH  forwarded rs2 value
FlushE  input  1  abort any in-flight op (branch/jump resolved in EXE)
MDBusyE  output  1  stall request to the hazard unit
MDDoneE  output  1  one-cycle pulse; MDResultE is valid
MDResultE  output  WIDTH  mul/div result

Behaviour:
- Reset: state=IDLE; MDBusyE=0, MDDoneE=0, MDResultE=0; internal accumulators cleared. rst has priority over every other input, including mid-operation.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, MDStartE=1, FlushE=0:
  - Latch operands and the op, converting to magnitudes per signedness.
  - Go to MUL (MDctrlE[2]=0) or DIV (MDctrlE[2]=1).
  - MDBusyE=1 combinationally in this same cycle (cycle T).
- MUL/DIV:
  - Shift-add multiply / restoring divide, one bit per cycle, counter 0..ITERS-1.
  - After ITERS cycles (T+1..T+32) go to DONE. MDBusyE=1 throughout.
- DONE (T+33):
  - MDDoneE=1 and MDBusyE=0; MDResultE is registered and valid.
  - The pipeline advances at the end of this cycle.
  - MDStartE is ignored in DONE, which prevents re-issuing the same held op. Next state is IDLE.
- Result selection:
  - MUL = low 32 bits of the 64-bit product.
  - MULH/MULHSU/MULHU = high 32 bits, sign-corrected: two's-complement negate the 64-bit product when exactly one signed operand is negative.
  - DIV/REM: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- Special cases (DIV path only). These bypass iteration: DIV -> DONE next cycle, latency 1, MDBusyE high only in cycle T.
  - Divide by zero: DIV/DIVU = 32'hFFFF_FFFF; REM/REMU = SrcAE.
  - Signed overflow (SrcAE=32'h8000_0000, SrcBE=32'hFFFF_FFFF, DIV/REM): quotient = 32'h8000_0000; remainder = 0.
- Flush:
  - FlushE=1 in any state forces next state IDLE and suppresses MDDoneE. MDBusyE=0 in that cycle.
  - FlushE together with MDStartE in IDLE means no op is started.
- MDResultE holds its last value when MDDoneE=0.
- All arithmetic is unsigned on magnitudes.
- The product register is 2*WIDTH bits. The divider keeps a WIDTH+1-bit partial remainder.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: all multiply ops use a single-cycle combinational WIDTH x WIDTH signed-extended product. IDLE goes to DONE directly, latency 1 (result at T+1).
- Undefined: multiply is iterative, latency 33.
- Divide is unaffected either way.

Decomposition:
- Package muldiv_pkg holds:
  - md_op_t enum (8 funct3 codes)
  - md_state_t enum (IDLE, MUL, DIV, DONE)
  - constants MD_XLEN=32, DIV0_QUOT=32'hFFFF_FFFF, INT_MIN=32'h8000_0000
- One sub-module, muldiv_sign_fix: combinational operand magnitude extraction and final result negation. It is shared by the mul and div paths.

Test Plan:
- MUL 7 x -3: start at T -> MDBusyE high T..T+32; MDDoneE at T+33; MDResultE=32'hFFFF_FFEB.
- MULHU FFFF_FFFF x FFFF_FFFF -> 32'hFFFF_FFFE; MULH of the same operands -> 0; MULHSU(-1, FFFF_FFFF) -> 32'hFFFF_FFFF.
- DIV -7 / 2 -> quotient 32'hFFFF_FFFD; REM -7 % 2 -> 32'hFFFF_FFFF; both at T+33.
- DIVU 100 / 0 -> 32'hFFFF_FFFF at T+1; REM 8000_0000 % FFFF_FFFF -> 0 at T+1.
- Flush at T+10 of a DIV -> MDBusyE=0 at T+10; no MDDoneE; a new DIVU 10/3 started at T+11 -> 3 at T+44.
- rst asserted at T+5 of a MUL -> next cycle: MDBusyE=0, MDDoneE=0, MDResultE=0, state IDLE. With MULDIV_FAST_MUL_EN defined: MUL 6 x 7 -> 42 at T+1.
